// File: rtl/aes_key_scheduler.sv
// AES-128 key scheduler: expands a cipher key into round keys rk0..rk10,
// one expansion round per clock, and serves them through a registered
// read port to the cipher round datapath.

// Combinational AES-128 key-expansion step.
// Computes the next round key from the current one.
// The count input selects the round constant (0 -> 8'h01 ... 9 -> 8'h36).
module key_expansion (
    input  logic [127:0] key,
    input  logic [3:0]   count,
    output logic [127:0] key_out
);

    // S-box packed row by row; byte 0x00 sits in the top 8 bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'd255 - x;
        return SBOX[{r, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] c);
        case (c)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word, sub_word, temp;
    logic [31:0] w4, w5, w6, w7;

    assign {w0, w1, w2, w3} = key;

    // RotWord, SubWord and rcon on w3, then the xor chain across the four words.
    always_comb begin
        // NOTE: every variable written here is assigned on every path, so no latch is inferred.
        rot_word = {w3[23:0], w3[31:24]};
        sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        temp     = sub_word ^ {rcon(count), 24'h000000};
        w4       = w0 ^ temp;
        w5       = w1 ^ w4;
        w6       = w2 ^ w5;
        w7       = w3 ^ w6;
    end

    assign key_out = {w4, w5, w6, w7};

endmodule

// Key scheduler top: FSM, round-key register file, and registered read port.
module aes_key_scheduler #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             keys_ready,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             rk_rd_valid
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [KEY_W-1:0] rk [0:NR];
    logic [KEY_W-1:0] next_key;
    logic             idx_ok;

    // The expansion counter doubles as the rcon index, and selects the source key.
    key_expansion u_key_expansion (
        .key     (rk[cnt]),
        .count   (cnt),
        .key_out (next_key)
    );

    assign idx_ok = (rk_rd_idx <= 4'(NR));

    // Control FSM: owns the round-key file, the counter and the status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            // NOTE: the round-key file is reset so a reset mid-expansion leaves no stale key material.
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, READY: begin
                    if (key_valid) begin
                        rk[0]      <= key_in;
                        cnt        <= 4'd0;
                        state      <= EXPAND;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[cnt + 4'd1] <= next_key;
                    if (cnt == 4'(NR - 1)) begin
                        cnt        <= 4'd0;
                        state      <= READY;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= 4'd0;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    keys_ready <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port: samples the key file before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_rd_data  <= '0;
            rk_rd_valid <= 1'b0;
        end else begin
            if (rk_rd_en) begin
                rk_rd_data <= idx_ok ? rk[rk_rd_idx] : '0;
            end
            rk_rd_valid <= rk_rd_en & keys_ready & idx_ok;
        end
    end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Bench for aes_key_scheduler: directed FIPS-197 and all-zero key vectors.
// Read expectations go through a scoreboard queue; a monitor pops one entry
// on the cycle after each read request and compares the registered response.
module tb_aes_key_scheduler;

    localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KZERO = 128'h0;
    localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] T1_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct packed {
        logic [127:0] data;
        logic         valid;
        logic [3:0]   idx;
    } rd_exp_t;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_ready;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;

    int      total = 0;
    int      bad   = 0;
    rd_exp_t sb_q[$];
    rd_exp_t mon_e;
    logic    rd_pending;

    aes_key_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_in      (key_in),
        .busy        (busy),
        .keys_ready  (keys_ready),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Track which edges carried a read request; the response appears after that edge.
    always @(posedge clk) rd_pending <= rk_rd_en;

    // Monitor: pop and compare one expected response per issued read.
    always @(negedge clk) begin
        if (rd_pending === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got data %h with no expected entry", rk_rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("rd_data idx%0d", mon_e.idx), rk_rd_data, mon_e.data);
                check($sformatf("rd_valid idx%0d", mon_e.idx), {127'b0, rk_rd_valid}, {127'b0, mon_e.valid});
            end
        end
    end

    task automatic push_read(input logic [3:0] idx, input logic [127:0] d, input logic v);
        sb_q.push_back('{data: d, valid: v, idx: idx});
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] d, input logic v);
        push_read(idx, d, v);
        @(negedge clk);
        rk_rd_en = 1'b0;
    endtask

    task automatic load(input logic [127:0] k);
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_n);
        int n;
        n = 0;
        while (keys_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(n), 128'(exp_n));
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst key_ready",   {127'b0, key_ready},   128'd1);
        check("rst busy",        {127'b0, busy},        128'd0);
        check("rst keys_ready",  {127'b0, keys_ready},  128'd0);
        check("rst rd_data",     rk_rd_data,            128'd0);
        check("rst rd_valid",    {127'b0, rk_rd_valid}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: FIPS-197 key, ready 10 cycles after accept
        load(K1);
        check("t1 busy",      {127'b0, busy},      128'd1);
        check("t1 key_ready", {127'b0, key_ready}, 128'd0);
        wait_ready("t1 latency", 10);
        check("t1 busy done", {127'b0, busy},      128'd0);

        // T2: back-to-back read sweep, out-of-range index, then hold with en low
        for (int i = 0; i <= 10; i++) begin
            push_read(4'(i), T1_RK[i], 1'b1);
            @(negedge clk);
        end
        push_read(4'd11, 128'd0, 1'b0);
        @(negedge clk);
        push_read(4'd5, T1_RK[5], 1'b1);
        @(negedge clk);
        rk_rd_en = 1'b0;
        @(negedge clk);
        check("t2 hold data",  rk_rd_data,            T1_RK[5]);
        check("t2 hold valid", {127'b0, rk_rd_valid}, 128'd0);

        // T3: key_valid held through EXPAND; second key only taken in READY
        load(KZERO);
        key_valid = 1'b1;
        key_in    = K1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3 key_ready c%0d", i), {127'b0, key_ready}, 128'd0);
            @(negedge clk);
        end
        check("t3 keys_ready", {127'b0, keys_ready}, 128'd1);
        check("t3 ready acc",  {127'b0, key_ready},  128'd1);
        @(negedge clk);
        key_valid = 1'b0;
        check("t3 keys_ready drop", {127'b0, keys_ready}, 128'd0);
        check("t3 busy again",      {127'b0, busy},       128'd1);
        wait_ready("t3 latency", 10);
        rd(4'd0,  T1_RK[0],  1'b1);
        rd(4'd10, T1_RK[10], 1'b1);

        // T4: reload in READY together with a read of idx 10 -> old key set
        key_valid = 1'b1;
        key_in    = KZERO;
        push_read(4'd10, T1_RK[10], 1'b1);
        @(negedge clk);
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        check("t4 keys_ready drop", {127'b0, keys_ready}, 128'd0);
        wait_ready("t4 latency", 10);
        rd(4'd0,  KZERO,  1'b1);
        rd(4'd1,  Z_RK1,  1'b1);
        rd(4'd10, Z_RK10, 1'b1);

        // T5: reset at cnt=5 aborts and clears; reload reproduces T1
        load(K1);
        repeat (5) @(negedge clk);
        check("t5 busy mid", {127'b0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("t5 key_ready",  {127'b0, key_ready},   128'd1);
        check("t5 busy",       {127'b0, busy},        128'd0);
        check("t5 keys_ready", {127'b0, keys_ready},  128'd0);
        check("t5 rd_data",    rk_rd_data,            128'd0);
        check("t5 rd_valid",   {127'b0, rk_rd_valid}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd1, 128'd0, 1'b0);
        load(K1);
        wait_ready("t5 latency", 10);
        rd(4'd1,  T1_RK[1],  1'b1);
        rd(4'd5,  T1_RK[5],  1'b1);
        rd(4'd10, T1_RK[10], 1'b1);

        // T6: reads during EXPAND are never valid; all-zero key expansion
        load(KZERO);
        push_read(4'd10, T1_RK[10], 1'b0);
        @(negedge clk);
        push_read(4'd0, KZERO, 1'b0);
        @(negedge clk);
        rk_rd_en = 1'b0;
        wait_ready("t6 latency", 8);
        rd(4'd1,  Z_RK1,  1'b1);
        rd(4'd10, Z_RK10, 1'b1);

        repeat (2) @(negedge clk);
        check("sb empty", 128'(sb_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
